bus_rr_xbar: RTL and testbench

- Parametrised successor to the single-host system bus: N hosts, M devices, base/mask address decode.
- Round-robin arbitration across hosts; one outstanding transaction at a time.
- Devices may respond with variable latency; unmapped addresses get an error response.
- Sits between Ibex data/debug-style masters and the RAM, SimCtrl and Timer devices in the next-generation simple system.

---
 rtl/bus_rr_xbar.sv | 222 ++++++++++++++++++++++
 tb/tb_bus_rr_xbar.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_xbar.sv
// N-host / M-device bus crossbar with round-robin arbitration and base/mask decode.
// Optional response timeout with TOUT error state, enabled by defining BUS_TIMEOUT_EN.
module bus_rr_xbar #(
    parameter int NrHosts       = 2,
    parameter int NrDevices     = 3,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_i,

    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,

    output logic [NrDevices-1:0]              device_req_o,
    output logic [AddressWidth-1:0]           device_addr_o,
    output logic                              device_we_o,
    output logic [DataWidth/8-1:0]            device_be_o,
    output logic [DataWidth-1:0]              device_wdata_o,
    input  logic [NrDevices-1:0]              device_rvalid_i,
    input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
    input  logic [NrDevices-1:0]              device_err_i,

    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i
);

    localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int BeW   = DataWidth / 8;

    if (NrHosts < 1 || NrDevices < 1 || (DataWidth % 8) != 0 || TimeoutCycles < 1) begin : g_param_check
        $error("bus_rr_xbar: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DERR = 2'd2
`ifdef BUS_TIMEOUT_EN
        , TOUT = 2'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [HostW-1:0]   rr_ptr_q;
    logic [HostW-1:0]   sel_host_q;
    logic [DevW-1:0]    sel_dev_q;

    // Rotate the request vector so bit 0 is the host at the pointer; lowest set bit wins.
    function automatic logic [HostW:0] rr_pick(input logic [NrHosts-1:0] req,
                                               input logic [HostW-1:0]   ptr);
        logic [2*NrHosts-1:0] dbl;
        logic [HostW:0]       res;
        int                   h;
        dbl = {req, req} >> ptr;
        res = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                h = int'(ptr) + i;
                if (h >= NrHosts) h = h - NrHosts;
                res = {1'b1, HostW'(h)};
            end
        end
        return res;
    endfunction

    function automatic logic [DevW:0] addr_decode(input logic [AddressWidth-1:0]           addr,
                                                  input logic [NrDevices*AddressWidth-1:0] base,
                                                  input logic [NrDevices*AddressWidth-1:0] mask);
        logic [DevW:0] res;
        res = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((addr & mask[d*AddressWidth +: AddressWidth]) == base[d*AddressWidth +: AddressWidth])
                res = {1'b1, DevW'(d)};
        end
        return res;
    endfunction

    logic                    arb_found;
    logic [HostW-1:0]        arb_host;
    logic                    dec_hit;
    logic [DevW-1:0]         dec_dev;
    logic [AddressWidth-1:0] g_addr;
    logic                    g_we;
    logic [BeW-1:0]          g_be;
    logic [DataWidth-1:0]    g_wdata;
    logic                    sel_rvalid;
    logic                    sel_err;
    logic [DataWidth-1:0]    sel_rdata;

    always_comb begin
        {arb_found, arb_host} = rr_pick(host_req_i, rr_ptr_q);
        g_addr  = '0;
        g_we    = 1'b0;
        g_be    = '0;
        g_wdata = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (HostW'(h) == arb_host) begin
                g_addr  = host_addr_i[h*AddressWidth +: AddressWidth];
                g_we    = host_we_i[h];
                g_be    = host_be_i[h*BeW +: BeW];
                g_wdata = host_wdata_i[h*DataWidth +: DataWidth];
            end
        end
        {dec_hit, dec_dev} = addr_decode(g_addr, cfg_device_addr_base_i, cfg_device_addr_mask_i);
    end

    // Only the latched device may complete the transaction.
    always_comb begin
        sel_rvalid = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (DevW'(d) == sel_dev_q) begin
                sel_rvalid = device_rvalid_i[d];
                sel_err    = device_err_i[d];
                sel_rdata  = device_rdata_i[d*DataWidth +: DataWidth];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] tout_cnt_q;
    logic            tout_hit;
    assign tout_hit = (tout_cnt_q == CntW'(TimeoutCycles - 1));
`endif

    always_comb begin
        state_d        = state_q;
        host_gnt_o     = '0;
        host_rvalid_o  = '0;
        host_err_o     = '0;
        host_rdata_o   = '0;
        device_req_o   = '0;
        device_addr_o  = '0;
        device_we_o    = 1'b0;
        device_be_o    = '0;
        device_wdata_o = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (arb_found) begin
                        host_gnt_o = NrHosts'(1) << arb_host;
                        if (dec_hit) begin
                            device_req_o   = NrDevices'(1) << dec_dev;
                            device_addr_o  = g_addr;
                            device_we_o    = g_we;
                            device_be_o    = g_be;
                            device_wdata_o = g_wdata;
                            state_d        = WAIT;
                        end else begin
                            state_d = DERR;
                        end
                    end
                end
                WAIT: begin
                    if (sel_rvalid) begin
                        host_rvalid_o = NrHosts'(1) << sel_host_q;
                        host_err_o    = sel_err ? (NrHosts'(1) << sel_host_q) : '0;
                        host_rdata_o  = sel_rdata;
                        state_d       = IDLE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tout_hit) begin
                        state_d = TOUT;
                    end
`endif
                end
                DERR: begin
                    host_rvalid_o = NrHosts'(1) << sel_host_q;
                    host_err_o    = NrHosts'(1) << sel_host_q;
                    state_d       = IDLE;
                end
`ifdef BUS_TIMEOUT_EN
                TOUT: begin
                    host_rvalid_o = NrHosts'(1) << sel_host_q;
                    host_err_o    = NrHosts'(1) << sel_host_q;
                    state_d       = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            sel_host_q <= '0;
            sel_dev_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && arb_found) begin
                sel_host_q <= arb_host;
                sel_dev_q  <= dec_dev;
                rr_ptr_q   <= (arb_host == HostW'(NrHosts - 1)) ? '0 : arb_host + 1'b1;
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != WAIT) begin
            tout_cnt_q <= '0;
        end else begin
            tout_cnt_q <= tout_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_rr_xbar.sv
// Directed self-checking bench for bus_rr_xbar (2 hosts: RAM, SimCtrl, Timer devices).
module tb_bus_rr_xbar;

    localparam int NH = 2;
    localparam int ND = 3;
    localparam int DW = 32;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NH-1:0]     host_req;
    logic [NH-1:0]     host_gnt;
    logic [NH*AW-1:0]  host_addr;
    logic [NH-1:0]     host_we;
    logic [NH*DW/8-1:0] host_be;
    logic [NH*DW-1:0]  host_wdata;
    logic [NH-1:0]     host_rvalid;
    logic [DW-1:0]     host_rdata;
    logic [NH-1:0]     host_err;
    logic [ND-1:0]     dev_req;
    logic [AW-1:0]     dev_addr;
    logic              dev_we;
    logic [DW/8-1:0]   dev_be;
    logic [DW-1:0]     dev_wdata;
    logic [ND-1:0]     dev_rvalid;
    logic [ND*DW-1:0]  dev_rdata;
    logic [ND-1:0]     dev_err;
    logic [ND*AW-1:0]  cfg_base;
    logic [ND*AW-1:0]  cfg_mask;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bus_rr_xbar #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .device_req_o(dev_req), .device_addr_o(dev_addr), .device_we_o(dev_we),
        .device_be_o(dev_be), .device_wdata_o(dev_wdata), .device_rvalid_i(dev_rvalid),
        .device_rdata_i(dev_rdata), .device_err_i(dev_err),
        .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        host_req = 2'b11;
        host_addr = {32'h0002_0000, 32'h0010_0004};
        dev_rvalid = 3'b111;
        dev_rdata = {3{32'hA5A5_A5A5}};
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            n_checks++; if (host_gnt !== 2'b00) $display("FAIL reset_gnt got %b want 00", host_gnt); else n_pass++;
            n_checks++; if (dev_req !== 3'b000) $display("FAIL reset_dev_req got %b want 000", dev_req); else n_pass++;
            n_checks++; if (host_rvalid !== 2'b00 || host_err !== 2'b00) $display("FAIL reset_rvalid_err got %b/%b want 00/00", host_rvalid, host_err); else n_pass++;
            n_checks++; if (host_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", host_rdata); else n_pass++;
        end
        tick(); rst = 1'b0; dev_rvalid = 3'b000; settle();
        n_checks++; if (host_gnt !== 2'b01) $display("FAIL reset_first_gnt got %b want 01", host_gnt); else n_pass++;
        n_checks++; if (dev_req !== 3'b001) $display("FAIL reset_first_req got %b want 001", dev_req); else n_pass++;
        tick(); rst = 1'b1; host_req = 2'b00; dev_rvalid = 3'b001; settle();
        n_checks++; if (host_rvalid !== 2'b00) $display("FAIL abandon_rvalid got %b want 00", host_rvalid); else n_pass++;
        tick(); rst = 1'b0; settle();
        n_checks++; if (host_rvalid !== 2'b00 || host_rdata !== 32'h0) $display("FAIL stray_idle got %b/%h want 00/0", host_rvalid, host_rdata); else n_pass++;
        tick(); dev_rvalid = 3'b000;
    endtask

    task automatic test_single_read();
        tick();
        host_req = 2'b01; host_addr[31:0] = 32'h0010_0004; host_we = 2'b00; host_be = 8'h0F;
        settle();
        n_checks++; if (host_gnt !== 2'b01) $display("FAIL read_gnt got %b want 01", host_gnt); else n_pass++;
        n_checks++; if (dev_req !== 3'b001) $display("FAIL read_dev_req got %b want 001", dev_req); else n_pass++;
        n_checks++; if (dev_addr !== 32'h0010_0004 || dev_we !== 1'b0 || dev_be !== 4'hF) $display("FAIL read_bcast got %h/%b/%h want 00100004/0/f", dev_addr, dev_we, dev_be); else n_pass++;
        tick(); host_req = 2'b00; dev_rvalid = 3'b001; dev_rdata[31:0] = 32'hDEAD_BEEF; settle();
        n_checks++; if (host_rvalid !== 2'b01) $display("FAIL read_rvalid got %b want 01", host_rvalid); else n_pass++;
        n_checks++; if (host_rdata !== 32'hDEAD_BEEF) $display("FAIL read_rdata got %h want deadbeef", host_rdata); else n_pass++;
        n_checks++; if (host_err !== 2'b00) $display("FAIL read_err got %b want 00", host_err); else n_pass++;
        tick(); dev_rvalid = 3'b000; settle();
        n_checks++; if (host_rvalid !== 2'b00 || host_rdata !== 32'h0) $display("FAIL read_after got %b/%h want 00/0", host_rvalid, host_rdata); else n_pass++;
    endtask

    task automatic test_decode_error();
        tick();
        host_req = 2'b10; host_addr[63:32] = 32'h5000_0000; host_we = 2'b10;
        settle();
        n_checks++; if (host_gnt !== 2'b10) $display("FAIL derr_gnt got %b want 10", host_gnt); else n_pass++;
        n_checks++; if (dev_req !== 3'b000) $display("FAIL derr_dev_req got %b want 000", dev_req); else n_pass++;
        tick(); host_req = 2'b00; host_we = 2'b00; dev_rvalid = 3'b111; dev_rdata = {3{32'h1234_5678}}; settle();
        n_checks++; if (host_rvalid !== 2'b10 || host_err !== 2'b10) $display("FAIL derr_resp got %b/%b want 10/10", host_rvalid, host_err); else n_pass++;
        n_checks++; if (host_rdata !== 32'h0) $display("FAIL derr_rdata got %h want 0", host_rdata); else n_pass++;
        tick(); dev_rvalid = 3'b000;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt;
        logic [31:0] exp_wdata;
        host_addr = {32'h0002_0000, 32'h0002_0000};
        host_wdata = {32'h2222_2222, 32'h1111_1111};
        host_we = 2'b01;
        for (int k = 0; k < 4; k++) begin
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_wdata = (k % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
            tick(); host_req = 2'b11; dev_rvalid = 3'b000; settle();
            n_checks++; if (host_gnt !== exp_gnt) $display("FAIL rr_gnt[%0d] got %b want %b", k, host_gnt, exp_gnt); else n_pass++;
            n_checks++; if (dev_req !== 3'b010 || dev_wdata !== exp_wdata || dev_we !== (k % 2 == 0)) $display("FAIL rr_bcast[%0d] got %b/%h/%b want 010/%h/%b", k, dev_req, dev_wdata, dev_we, exp_wdata, (k % 2 == 0)); else n_pass++;
            tick(); dev_rvalid = 3'b010; dev_rdata[63:32] = 32'h1000 + k; settle();
            n_checks++; if (host_rvalid !== exp_gnt || host_gnt !== 2'b00) $display("FAIL rr_resp[%0d] got %b/%b want %b/00", k, host_rvalid, host_gnt, exp_gnt); else n_pass++;
            n_checks++; if (host_rdata !== 32'h1000 + k) $display("FAIL rr_rdata[%0d] got %h want %h", k, host_rdata, 32'h1000 + k); else n_pass++;
        end
        tick(); host_req = 2'b00; host_we = 2'b00; dev_rvalid = 3'b000;
    endtask

    task automatic test_variable_latency();
        tick();
        host_req = 2'b10; host_addr = {32'h0003_0004, 32'h0010_0008};
        settle();
        n_checks++; if (host_gnt !== 2'b10 || dev_req !== 3'b100) $display("FAIL vl_gnt got %b/%b want 10/100", host_gnt, dev_req); else n_pass++;
        for (int c = 1; c <= 4; c++) begin
            tick(); host_req = 2'b01; dev_rvalid = (c == 2) ? 3'b001 : 3'b000; dev_rdata[31:0] = 32'hBAD0_BAD0; settle();
            n_checks++; if (host_gnt !== 2'b00 || host_rvalid !== 2'b00) $display("FAIL vl_wait[%0d] got %b/%b want 00/00", c, host_gnt, host_rvalid); else n_pass++;
        end
        tick(); dev_rvalid = 3'b100; dev_err = 3'b100; dev_rdata[95:64] = 32'hCAFE_F00D; settle();
        n_checks++; if (host_rvalid !== 2'b10 || host_err !== 2'b10) $display("FAIL vl_resp got %b/%b want 10/10", host_rvalid, host_err); else n_pass++;
        n_checks++; if (host_rdata !== 32'hCAFE_F00D || host_gnt !== 2'b00) $display("FAIL vl_rdata got %h/%b want cafef00d/00", host_rdata, host_gnt); else n_pass++;
        tick(); dev_rvalid = 3'b000; dev_err = 3'b000; settle();
        n_checks++; if (host_gnt !== 2'b01 || dev_req !== 3'b001 || dev_addr !== 32'h0010_0008) $display("FAIL vl_next_gnt got %b/%b/%h want 01/001/00100008", host_gnt, dev_req, dev_addr); else n_pass++;
        tick(); host_req = 2'b00; dev_rvalid = 3'b001; dev_rdata[31:0] = 32'h0000_0042; settle();
        n_checks++; if (host_rvalid !== 2'b01 || host_err !== 2'b00 || host_rdata !== 32'h42) $display("FAIL vl_next_resp got %b/%b/%h want 01/00/42", host_rvalid, host_err, host_rdata); else n_pass++;
        tick(); dev_rvalid = 3'b000;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt;
        for (int k = 0; k < 6; k++) begin
            exp_gnt = (k % 2 == 0) ? 2'b10 : 2'b00;
            tick(); host_req = 2'b10; host_addr[63:32] = 32'h0002_0000;
            dev_rvalid = (k % 2 == 1) ? 3'b010 : 3'b000; settle();
            n_checks++; if (host_gnt !== exp_gnt) $display("FAIL b2b_gnt[%0d] got %b want %b", k, host_gnt, exp_gnt); else n_pass++;
        end
        tick(); host_req = 2'b00; dev_rvalid = 3'b000;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        tick(); host_req = 2'b01; host_addr[31:0] = 32'h0010_0000; settle();
        n_checks++; if (host_gnt !== 2'b01) $display("FAIL tout_gnt got %b want 01", host_gnt); else n_pass++;
        for (int c = 1; c <= 4; c++) begin
            tick(); host_req = 2'b00; settle();
            n_checks++; if (host_rvalid !== 2'b00) $display("FAIL tout_wait[%0d] got %b want 00", c, host_rvalid); else n_pass++;
        end
        tick(); settle();
        n_checks++; if (host_rvalid !== 2'b01 || host_err !== 2'b01 || host_rdata !== 32'h0) $display("FAIL tout_resp got %b/%b/%h want 01/01/0", host_rvalid, host_err, host_rdata); else n_pass++;
        tick(); settle();
        n_checks++; if (host_rvalid !== 2'b00) $display("FAIL tout_idle got %b want 00", host_rvalid); else n_pass++;
        tick(); dev_rvalid = 3'b001; dev_rdata[31:0] = 32'h7777_7777; settle();
        n_checks++; if (host_rvalid !== 2'b00 || host_rdata !== 32'h0) $display("FAIL tout_late got %b/%h want 00/0", host_rvalid, host_rdata); else n_pass++;
        tick(); dev_rvalid = 3'b000;
    endtask
`endif

    initial begin
        rst = 1'b1;
        host_req = '0; host_addr = '0; host_we = '0; host_be = '0; host_wdata = '0;
        dev_rvalid = '0; dev_rdata = '0; dev_err = '0;
        cfg_base = {32'h0003_0000, 32'h0002_0000, 32'h0010_0000};
        cfg_mask = {~32'h3FF, ~32'h3FF, ~32'hF_FFFF};
        test_reset();
        test_single_read();
        test_decode_error();
        test_round_robin();
        test_variable_latency();
        test_back_to_back();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
